// File: rtl/rd_hazard_tracker_pkg.sv
// Shared types and constants for the destination-register hazard tracker:
// forwarding-select codes, stage-entry structs and the effective-write helper.
package rd_hazard_tracker_pkg;

    localparam int RD_W         = 5;
    localparam int ZERO_REG_DEF = 31;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            rw;
        logic            mr;
        logic [RD_W-1:0] rn;
        logic [RD_W-1:0] rm;
        logic            rn_used;
        logic            rm_used;
    } ex_entry_t;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            rw;
    } mw_entry_t;

    // A write to the zero register is architecturally discarded, so it never counts.
    function automatic logic eff_write(input logic [RD_W-1:0] rd,
                                       input logic            rw,
                                       input logic [RD_W-1:0] zero_rd);
        return rw & (rd != zero_rd);
    endfunction

endpackage

// File: rtl/rd_hazard_tracker_fwd_select.sv
// EX-stage operand forwarding select for one source operand; the MEM producer
// is newer than the WB producer, so it is checked first.
module rd_hazard_tracker_fwd_select
    import rd_hazard_tracker_pkg::*;
#(
    parameter logic [RD_W-1:0] ZERO_RD = 5'd31
) (
    input  logic [RD_W-1:0] src_i,
    input  logic            src_used_i,
    input  mw_entry_t       mem_i,
    input  mw_entry_t       wb_i,
    output logic [1:0]      sel_o
);

    // Priority select between the MEM and WB producers.
    always_comb begin
        sel_o = FWD_RF;
        if (src_used_i && eff_write(mem_i.rd, mem_i.rw, ZERO_RD) && (mem_i.rd == src_i)) begin
            sel_o = FWD_MEM;
        end else if (src_used_i && eff_write(wb_i.rd, wb_i.rw, ZERO_RD) && (wb_i.rd == src_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/rd_hazard_tracker.sv
// Tracks EX/MEM/WB destination registers beside the pipeline registers and
// produces forwarding selects, the load-use stall and the write-back enable.
module rd_hazard_tracker
    import rd_hazard_tracker_pkg::*;
#(
    parameter int REG_W    = RD_W,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] ex_rd,
    output logic [REG_W-1:0] mem_rd,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_reg_write
);

    localparam logic [RD_W-1:0] ZERO_RD = RD_W'(ZERO_REG);

    ex_entry_t ex_q, ex_d;
    mw_entry_t mem_q, mem_d;
    mw_entry_t wb_q, wb_d;
    mw_entry_t ex_mw_s;
    logic      hz_s;

    assign ex_mw_s = '{rd: ex_q.rd, rw: ex_q.rw};

    // Load-use detection against the load currently in EX; a flush overrides it.
    always_comb begin
        hz_s = 1'b0;
        if (id_valid && ex_q.mr && eff_write(ex_q.rd, ex_q.rw, ZERO_RD)) begin
            hz_s = (id_rn_used && (id_rn == ex_q.rd)) || (id_rm_used && (id_rm == ex_q.rd));
        end else begin
            hz_s = 1'b0;
        end
    end

    assign stall = hz_s & ~flush;

    // Next-state: shift entries down the pipe, inserting bubbles on flush/stall/idle.
    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_mw_s;
        ex_d  = '0;
        if (flush) begin
            mem_d = '0;
        end else begin
            mem_d = ex_mw_s;
        end
        if (flush || stall || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = '{rd: id_rd, rw: id_reg_write, mr: id_mem_read,
                     rn: id_rn, rm: id_rm,
                     rn_used: id_rn_used, rm_used: id_rm_used};
        end
    end

    // Stage entry registers; Reset discards every pending entry.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    rd_hazard_tracker_fwd_select #(.ZERO_RD(ZERO_RD)) u_fwd_a (
        .src_i      (ex_q.rn),
        .src_used_i (ex_q.rn_used),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .sel_o      (fwd_a)
    );

    rd_hazard_tracker_fwd_select #(.ZERO_RD(ZERO_RD)) u_fwd_b (
        .src_i      (ex_q.rm),
        .src_used_i (ex_q.rm_used),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .sel_o      (fwd_b)
    );

    assign ex_rd        = ex_q.rd;
    assign mem_rd       = mem_q.rd;
    assign wb_rd        = wb_q.rd;
    assign wb_reg_write = eff_write(wb_q.rd, wb_q.rw, ZERO_RD);

endmodule

// File: tb/tb_rd_hazard_tracker.sv
// Directed table-driven bench for rd_hazard_tracker: each row is one cycle of
// ID inputs plus the outputs expected while those inputs are applied.
module tb_rd_hazard_tracker;

    logic       clk = 1'b0;
    logic       Reset;
    logic       id_valid, id_rn_used, id_rm_used, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       stall, wb_reg_write;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] ex_rd, mem_rd, wb_rd;

    int n_tests = 0;
    int n_fail  = 0;

    rd_hazard_tracker dut (
        .clk          (clk),
        .Reset        (Reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rn_used   (id_rn_used),
        .id_rm_used   (id_rm_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .ex_rd        (ex_rd),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, valid;
        logic [4:0] rn, rm;
        logic       rnu, rmu;
        logic [4:0] rd;
        logic       rw, mr, fl;
        logic       e_stall;
        logic [1:0] e_fa, e_fb;
        logic [4:0] e_ex, e_mem, e_wb;
        logic       e_wbw;
    } vec_t;

    localparam int NV = 39;
    vec_t vecs [NV];

    function automatic vec_t v(int rst, int valid, int rn, int rm, int rnu, int rmu,
                               int rd, int rw, int mr, int fl,
                               int st, int fa, int fb, int ex, int mem, int wb, int wbw);
        vec_t r;
        r.rst = rst[0];  r.valid = valid[0]; r.rn = rn[4:0]; r.rm = rm[4:0];
        r.rnu = rnu[0];  r.rmu = rmu[0];     r.rd = rd[4:0]; r.rw = rw[0];
        r.mr = mr[0];    r.fl = fl[0];
        r.e_stall = st[0]; r.e_fa = fa[1:0]; r.e_fb = fb[1:0];
        r.e_ex = ex[4:0];  r.e_mem = mem[4:0]; r.e_wb = wb[4:0]; r.e_wbw = wbw[0];
        return r;
    endfunction

    function automatic vec_t nop(int st, int fa, int fb, int ex, int mem, int wb, int wbw);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, fa, fb, ex, mem, wb, wbw);
    endfunction

    task automatic check(input string name, input int row, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        Reset = t.rst; id_valid = t.valid; id_rn = t.rn; id_rm = t.rm;
        id_rn_used = t.rnu; id_rm_used = t.rmu; id_rd = t.rd;
        id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl;
    endtask

    task automatic check_outputs(input int row, input vec_t t);
        check("stall",        row, int'(stall),        int'(t.e_stall));
        check("fwd_a",        row, int'(fwd_a),        int'(t.e_fa));
        check("fwd_b",        row, int'(fwd_b),        int'(t.e_fb));
        check("ex_rd",        row, int'(ex_rd),        int'(t.e_ex));
        check("mem_rd",       row, int'(mem_rd),       int'(t.e_mem));
        check("wb_rd",        row, int'(wb_rd),        int'(t.e_wb));
        check("wb_reg_write", row, int'(wb_reg_write), int'(t.e_wbw));
    endtask

    initial begin
        //             rst vl rn rm nu mu rd rw mr fl | st fa fb ex mem wb wbw
        vecs[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // ADD X1 then SUB X7,X1,X4
        vecs[1]  = v(0, 1, 2, 3, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = v(0, 1, 1, 4, 1, 1, 7, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        vecs[3]  = nop(0, 2, 0, 7, 1, 0, 0);
        vecs[4]  = nop(0, 0, 0, 0, 7, 1, 1);
        vecs[5]  = nop(0, 0, 0, 0, 0, 7, 1);
        // ADD X2, NOP, ORR X8,X9,X2
        vecs[6]  = v(0, 1, 10, 11, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = nop(0, 0, 0, 2, 0, 0, 0);
        vecs[8]  = v(0, 1, 9, 2, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 2, 0, 0);
        vecs[9]  = nop(0, 0, 1, 8, 0, 2, 1);
        vecs[10] = nop(0, 0, 0, 0, 8, 0, 0);
        // LDUR X3 then ADD X4,X3,X5 (held during stall)
        vecs[11] = v(0, 1, 12, 0, 1, 0, 3, 1, 1, 0,  0, 0, 0, 0, 0, 8, 1);
        vecs[12] = v(0, 1, 3, 5, 1, 1, 4, 1, 0, 0,   1, 0, 0, 3, 0, 0, 0);
        vecs[13] = v(0, 1, 3, 5, 1, 1, 4, 1, 0, 0,   0, 0, 0, 0, 3, 0, 0);
        vecs[14] = nop(0, 1, 0, 4, 0, 3, 1);
        // ADD X9, LDUR X3, load-use consumer with flush
        vecs[15] = v(0, 1, 13, 0, 1, 0, 9, 1, 0, 0,  0, 0, 0, 0, 4, 0, 0);
        vecs[16] = v(0, 1, 12, 0, 1, 0, 3, 1, 1, 0,  0, 0, 0, 9, 0, 4, 1);
        vecs[17] = v(0, 1, 3, 5, 1, 1, 4, 1, 0, 1,   0, 0, 0, 3, 9, 0, 0);
        vecs[18] = nop(0, 0, 0, 0, 0, 9, 1);
        vecs[19] = nop(0, 0, 0, 0, 0, 0, 0);
        // LDUR XZR then two readers of X31
        vecs[20] = v(0, 1, 1, 0, 1, 0, 31, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[21] = v(0, 1, 31, 31, 1, 1, 5, 1, 0, 0, 0, 0, 0, 31, 0, 0, 0);
        vecs[22] = v(0, 1, 31, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 5, 31, 0, 0);
        vecs[23] = nop(0, 0, 0, 10, 5, 31, 0);
        vecs[24] = nop(0, 0, 0, 0, 10, 5, 1);
        vecs[25] = nop(0, 0, 0, 0, 0, 10, 1);
        // ADD X6, ADD X6, reader of X6, then Reset mid-stream
        vecs[26] = v(0, 1, 1, 1, 1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        vecs[27] = v(0, 1, 2, 2, 1, 1, 6, 1, 0, 0,   0, 0, 0, 6, 0, 0, 0);
        vecs[28] = v(0, 1, 6, 6, 1, 1, 7, 1, 0, 0,   0, 0, 0, 6, 6, 0, 0);
        vecs[29] = v(1, 1, 20, 0, 1, 0, 11, 1, 0, 0, 0, 2, 2, 7, 6, 6, 1);
        vecs[30] = nop(0, 0, 0, 0, 0, 0, 0);
        vecs[31] = nop(0, 0, 0, 0, 0, 0, 0);
        // load-use through Rm, then consumer with id_valid=0
        vecs[32] = v(0, 1, 1, 0, 1, 0, 12, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[33] = v(0, 1, 14, 12, 1, 1, 13, 1, 0, 0, 1, 0, 0, 12, 0, 0, 0);
        vecs[34] = v(0, 1, 14, 12, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 12, 0, 0);
        vecs[35] = nop(0, 0, 1, 13, 0, 12, 1);
        vecs[36] = v(0, 1, 1, 0, 1, 0, 14, 1, 1, 0,  0, 0, 0, 0, 13, 0, 0);
        vecs[37] = v(0, 0, 14, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 14, 0, 13, 1);
        vecs[38] = nop(0, 0, 0, 0, 14, 0, 0);

        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check_outputs(i, vecs[i]);
        end

        // Reset held for several cycles while a load and its consumer are presented.
        @(negedge clk);
        apply(v(0, 1, 1, 0, 1, 0, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        apply(v(0, 1, 15, 15, 1, 1, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        #1;
        check("hold_ex_before_reset", 100, int'(ex_rd), 15);
        check("hold_stall_during_reset", 100, int'(stall), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rst_ex_rd",  101 + k, int'(ex_rd),        0);
            check("rst_mem_rd", 101 + k, int'(mem_rd),       0);
            check("rst_wbw",    101 + k, int'(wb_reg_write), 0);
            check("rst_stall",  101 + k, int'(stall),        0);
        end
        @(negedge clk);
        apply(nop(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        check("post_rst_ex_rd", 110, int'(ex_rd), 0);
        check("post_rst_wbw",   110, int'(wb_reg_write), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
